// File: rtl/rgb_led_sequencer_if.sv
// rgb_led_if: control/status bundle for one rgb_led_sequencer instance.
//   master: control logic side (drives en/mode/colour, reads LEDs and step status)
//   slave : the sequencer itself
//   i_en, i_mode[1:0], i_color_in[2:0] ({R,G,B}), i_duty[PWM_W-1:0] (RGB_PWM_EN only)
//   o_led_R/G/B, o_step_pulse, o_step_count[CNT_W-1:0]
// Optional feature macro: RGB_PWM_EN (adds PWM_W parameter and i_duty).
interface rgb_led_if #(
  parameter int CNT_W = 32
`ifdef RGB_PWM_EN
  , parameter int PWM_W = 8
`endif
);
  logic             i_en;
  logic [1:0]       i_mode;
  logic [2:0]       i_color_in;
`ifdef RGB_PWM_EN
  logic [PWM_W-1:0] i_duty;
`endif
  logic             o_led_R;
  logic             o_led_G;
  logic             o_led_B;
  logic             o_step_pulse;
  logic [CNT_W-1:0] o_step_count;

  modport master (
    output i_en, i_mode, i_color_in,
`ifdef RGB_PWM_EN
    output i_duty,
`endif
    input  o_led_R, o_led_G, o_led_B, o_step_pulse, o_step_count
  );

  modport slave (
    input  i_en, i_mode, i_color_in,
`ifdef RGB_PWM_EN
    input  i_duty,
`endif
    output o_led_R, o_led_G, o_led_B, o_step_pulse, o_step_count
  );
endinterface

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: RGB status-LED driver. A prescaler produces a step tick every
// TICK_DIV enabled clocks; a mode FSM turns steps into OFF / BLINK / CYCLE / STATIC
// colour patterns on registered, active-high LED outputs.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - rgb_led_if.slave (en, mode, colour, [duty], LEDs, step pulse/count)
// Optional feature macro: RGB_PWM_EN - free-running PWM counter gates all LEDs by i_duty.
module rgb_led_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 32,
  parameter int PWM_W    = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  rgb_led_if.slave  bus
);

  if (TICK_DIV < 1 || CNT_W < 1 || PWM_W < 1) begin : g_bad_param
    $error("rgb_led_sequencer: TICK_DIV, CNT_W and PWM_W must be >= 1");
  end

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] M_OFF    = 2'b00;
  localparam logic [1:0] M_BLINK  = 2'b01;
  localparam logic [1:0] M_CYCLE  = 2'b10;
  localparam logic [1:0] M_STATIC = 2'b11;

  typedef enum logic [1:0] {S_RED, S_GREEN, S_BLUE} cyc_state_t;

  cyc_state_t       r_cstate, w_cstate_nxt;
  logic [CNT_W-1:0] r_presc, w_presc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             r_phase, w_phase_nxt;   // 1 = blink ON half
  logic [1:0]       r_mode_q, w_mode_q_nxt;
  logic [2:0]       r_color_q, w_color_q_nxt;
  logic [2:0]       r_col, w_col;
  logic             w_mode_chg;
  logic             w_tick;
  logic [2:0]       w_cyc_col;

  always_comb begin
    unique case (r_cstate)
      S_RED:   w_cyc_col = 3'b100;
      S_GREEN: w_cyc_col = 3'b010;
      default: w_cyc_col = 3'b001;
    endcase
  end

  // Mode change restarts the pattern and suppresses a coinciding step.
  assign w_mode_chg = (bus.i_mode != r_mode_q);
  assign w_tick     = (r_presc == LastCnt) && !w_mode_chg;

  always_comb begin
    w_presc_nxt   = r_presc;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = 1'b0;
    w_phase_nxt   = r_phase;
    w_cstate_nxt  = r_cstate;
    w_mode_q_nxt  = r_mode_q;
    w_color_q_nxt = r_color_q;
    w_col         = r_col;
    if (bus.i_en) begin
      w_mode_q_nxt = bus.i_mode;
      if (w_mode_chg) begin
        w_presc_nxt   = '0;
        w_phase_nxt   = 1'b1;
        w_cstate_nxt  = S_RED;
        w_color_q_nxt = bus.i_color_in;
      end else if (w_tick) begin
        w_presc_nxt   = '0;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_pulse_nxt   = 1'b1;
        w_phase_nxt   = ~r_phase;
        w_color_q_nxt = bus.i_color_in;
        unique case (r_cstate)
          S_RED:   w_cstate_nxt = S_GREEN;
          S_GREEN: w_cstate_nxt = S_BLUE;
          default: w_cstate_nxt = S_RED;
        endcase
      end else begin
        w_presc_nxt = r_presc + CNT_W'(1);
      end
      // On the entry cycle the state registers still hold the old mode's values,
      // so show the entry colour directly.
      unique case (bus.i_mode)
        M_OFF:    w_col = 3'b000;
        M_BLINK:  w_col = w_mode_chg ? bus.i_color_in : (r_phase ? r_color_q : 3'b000);
        M_CYCLE:  w_col = w_mode_chg ? 3'b100 : w_cyc_col;
        M_STATIC: w_col = bus.i_color_in;
        default:  w_col = 3'b000;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_phase   <= 1'b1;
      r_cstate  <= S_RED;
      r_mode_q  <= M_OFF;
      r_color_q <= 3'b000;
      r_col     <= 3'b000;
    end else begin
      r_presc   <= w_presc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_phase   <= w_phase_nxt;
      r_cstate  <= w_cstate_nxt;
      r_mode_q  <= w_mode_q_nxt;
      r_color_q <= w_color_q_nxt;
      r_col     <= w_col;
    end
  end

  assign bus.o_step_pulse = r_pulse;
  assign bus.o_step_count = r_cnt;

`ifdef RGB_PWM_EN
  // PWM runs even when en=0 so held colours keep their brightness.
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [2:0]       r_led;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      r_led     <= 3'b000;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      r_led     <= w_col & {3{r_pwm_cnt < bus.i_duty}};
    end
  end

  assign {bus.o_led_R, bus.o_led_G, bus.o_led_B} = r_led;
`else
  assign {bus.o_led_R, bus.o_led_G, bus.o_led_B} = r_col;
`endif

endmodule

// File: tb/tb_rgb_led_sequencer.sv
module tb_rgb_led_sequencer;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 8;
  localparam int PWM_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef RGB_PWM_EN
  rgb_led_if #(.CNT_W(CNT_W), .PWM_W(PWM_W)) bus ();
`else
  rgb_led_if #(.CNT_W(CNT_W)) bus ();
`endif

  rgb_led_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .PWM_W(PWM_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string            tag;
    logic [2:0]       leds;
    logic             pulse;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: outputs are presented every cycle; pop one expectation per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if ({bus.o_led_R, bus.o_led_G, bus.o_led_B} !== mon_e.leds) begin
        n_bad++;
        $display("FAIL %s leds: got %b want %b", mon_e.tag,
                 {bus.o_led_R, bus.o_led_G, bus.o_led_B}, mon_e.leds);
      end
      n_cmp++;
      if (bus.o_step_pulse !== mon_e.pulse) begin
        n_bad++;
        $display("FAIL %s step_pulse: got %b want %b", mon_e.tag, bus.o_step_pulse, mon_e.pulse);
      end
      n_cmp++;
      if (bus.o_step_count !== mon_e.cnt) begin
        n_bad++;
        $display("FAIL %s step_count: got %0d want %0d", mon_e.tag, bus.o_step_count, mon_e.cnt);
      end
    end
  end

  // Advance one edge (inputs already driven) and queue what must appear after it.
  task automatic tick(input string tag, input logic [2:0] l, input logic p, input int c);
    exp_t x;
    @(posedge clk);
    #1;
    x.tag = tag; x.leds = l; x.pulse = p; x.cnt = CNT_W'(c);
    sb.push_back(x);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick("reset", 3'b000, 1'b0, 0);
    rst = 1'b0;
  endtask

  // CYCLE: t = enabled edges since mode entry (t=0 is the entry edge).
  function automatic logic [2:0] cyc_col(input int t);
    if (t == 0) return 3'b100;
    case (((t - 1) / 4) % 3)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // BLINK with color_in 110, switched to 011 after edge t=10.
  function automatic logic [2:0] blink_col(input int t);
    int p;
    if (t == 0) return 3'b110;
    p = (t - 1) / 4;
    if (p % 2 == 1) return 3'b000;
    return (p >= 4) ? 3'b011 : 3'b110;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_en       = 1'b1;
    bus.i_mode     = 2'b10;
    bus.i_color_in = 3'b000;
`ifdef RGB_PWM_EN
    bus.i_duty     = '1;
`endif

    // 1: CYCLE from reset
    do_reset(2);
    for (int t = 0; t <= 18; t++)
      tick("cycle", cyc_col(t), (t > 0) && (t % 4 == 0), t / 4);

    // 3: freeze mid-step (prescaler at 2), then resume
    bus.i_en = 1'b0;
    repeat (10) tick("freeze", cyc_col(18), 1'b0, 4);
    bus.i_en = 1'b1;
    for (int t = 19; t <= 27; t++)
      tick("resume", cyc_col(t), (t % 4 == 0), t / 4);

    // 4: switch to STATIC on the edge that would have been a step
    bus.i_mode = 2'b11;
    bus.i_color_in = 3'b101;
    tick("chg_wins", 3'b101, 1'b0, 6);
    tick("static", 3'b101, 1'b0, 6);
    bus.i_color_in = 3'b010;
    tick("static_col", 3'b010, 1'b0, 6);
    tick("static_col", 3'b010, 1'b0, 6);
    tick("static_step", 3'b010, 1'b1, 7);
    tick("static_post", 3'b010, 1'b0, 7);

    // 2: BLINK, colour changed mid-ON phase
    bus.i_mode = 2'b01;
    bus.i_color_in = 3'b110;
    do_reset(2);
    for (int t = 0; t <= 24; t++) begin
      tick("blink", blink_col(t), (t > 0) && (t % 4 == 0), t / 4);
      if (t == 10) bus.i_color_in = 3'b011;
    end

    // 5: OFF from reset, 258 steps -> step_count wraps
    bus.i_mode = 2'b00;
    do_reset(2);
    for (int r = 1; r <= 1032; r++)
      tick("wrap", 3'b000, (r % 4 == 0), (r / 4) % 256);

`ifdef RGB_PWM_EN
    // 6: PWM gating
    bus.i_mode = 2'b11;
    bus.i_color_in = 3'b111;
    bus.i_duty = 4'd4;
    do_reset(2);
    for (int k = 1; k <= 32; k++)
      tick("pwm4", ((k - 1) % 16 < 4) ? 3'b111 : 3'b000, (k > 1) && ((k - 1) % 4 == 0), (k - 1) / 4);
    bus.i_duty = 4'd0;
    for (int k = 33; k <= 48; k++)
      tick("pwm0", 3'b000, ((k - 1) % 4 == 0), (k - 1) / 4);
    bus.i_duty = 4'd4;
    for (int k = 49; k <= 54; k++)
      tick("pwm_mid", ((k - 1) % 16 < 4) ? 3'b111 : 3'b000, ((k - 1) % 4 == 0), (k - 1) / 4);
    do_reset(1);
    for (int k = 1; k <= 6; k++)
      tick("pwm_rst", (k <= 4) ? 3'b111 : 3'b000, (k == 5), (k - 1) / 4);
`endif

    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
